// File: rtl/divider_4bit_pkg.sv
// Shared types and constants for the 4-bit restoring divider.
// State encodings and the iteration count used by the control FSM.
package divider_4bit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int ITERS = 4;

endpackage

// File: rtl/divider_4bit_subtractor.sv
// Ripple subtractor built from 1-bit full adders: a + ~b + ~bin.
// Borrow-out is the inverted final carry.
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module subtractor_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bin,
  output logic [3:0] diff,
  output logic       bout
);

  logic [4:0] c;

  assign c[0] = ~bin;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    full_adder_1bit u_fa (
      .a   (a[i]),
      .b   (~b[i]),
      .cin (c[i]),
      .sum (diff[i]),
      .cout(c[i+1])
    );
  end

  assign bout = ~c[4];

endmodule

// File: rtl/divider_4bit.sv
// Sequential 4-bit unsigned restoring divider with start/busy/done
// handshake; one quotient bit per RUN cycle.
module divider_4bit
  import divider_4bit_pkg::*;
#(
  parameter logic [3:0] DIV0_QUOTIENT = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       div_by_zero
);

  state_t     state;
  state_t     state_nx;
  logic [3:0] q;
  logic [3:0] r;
  logic [3:0] d;
  logic [1:0] cnt;
  logic [4:0] p;
  logic [3:0] diff;
  logic       bout;
  logic       take;
  logic [3:0] q_nx;
  logic [3:0] r_nx;
  logic       accept;
  logic       div0;
  logic       last;

  assign p = {r, q[3]};

  subtractor_4bit u_sub (
    .a   (p[3:0]),
    .b   (d),
    .bin (1'b0),
    .diff(diff),
    .bout(bout)
  );

  // p[4] set means p >= 16 > d, so the subtraction always succeeds
  assign take   = p[4] | ~bout;
  assign q_nx   = {q[2:0], take};
  assign r_nx   = take ? diff : p[3:0];
  assign accept = (state == IDLE) && start;
  assign div0   = (divisor == 4'd0);
  assign last   = (cnt == 2'(ITERS - 1));

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start) state_nx = div0 ? DONE : RUN;
      end
      RUN: begin
        if (last) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q           <= '0;
      r           <= '0;
      d           <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q   <= dividend;
      r   <= '0;
      d   <= divisor;
      cnt <= '0;
      if (div0) begin
        quotient    <= DIV0_QUOTIENT;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        quotient    <= '0;
        remainder   <= '0;
        div_by_zero <= 1'b0;
      end
    end else if (state == RUN) begin
      q   <= q_nx;
      r   <= r_nx;
      cnt <= cnt + 2'd1;
      if (last) begin
        quotient  <= q_nx;
        remainder <= r_nx;
      end
    end
  end

endmodule

// File: tb/tb_divider_4bit.sv
// Directed bench for divider_4bit: handshake timing, zero divisor,
// ignored starts, mid-run reset and a full operand sweep.
module tb_divider_4bit;

  logic       clk;
  logic       rst;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int tests;
  int fails;

  divider_4bit #(.DIV0_QUOTIENT(4'b1111)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic do_div(input int a, input int b,
                        input int eq, input int er, input int ez);
    start    = 1'b1;
    dividend = 4'(a);
    divisor  = 4'(b);
    tick();
    start    = 1'b0;
    dividend = ~4'(a);
    divisor  = ~4'(b);
    chk("busy_n", int'(busy), 1);
    if (b == 0) begin
      chk("done_n0", int'(done), 1);
      chk("quot_z", int'(quotient), eq);
      chk("rem_z", int'(remainder), er);
      chk("dbz_z", int'(div_by_zero), ez);
      tick();
      chk("done_n1z", int'(done), 0);
      chk("busy_n1z", int'(busy), 0);
    end else begin
      chk("done_n", int'(done), 0);
      for (int k = 0; k < 3; k++) begin
        tick();
        chk("done_run", int'(done), 0);
      end
      tick();
      chk("done_n4", int'(done), 1);
      chk("busy_n4", int'(busy), 1);
      chk("quot", int'(quotient), eq);
      chk("rem", int'(remainder), er);
      chk("dbz", int'(div_by_zero), ez);
      tick();
      chk("done_n5", int'(done), 0);
      chk("busy_n5", int'(busy), 0);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = 4'd0;
    divisor  = 4'd0;
    tick();
    tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_quot", int'(quotient), 0);
    chk("rst_rem", int'(remainder), 0);
    chk("rst_dbz", int'(div_by_zero), 0);
    rst = 1'b0;
    tick();

    do_div(13, 3, 4, 1, 0);
    do_div(15, 1, 15, 0, 0);
    do_div(7, 9, 0, 7, 0);
    do_div(8, 8, 1, 0, 0);
    do_div(9, 0, 15, 9, 1);
    chk("hold_dbz", int'(div_by_zero), 1);
    chk("hold_quot", int'(quotient), 15);
    do_div(6, 2, 3, 0, 0);

    // starts during RUN and DONE must be ignored
    start    = 1'b1;
    dividend = 4'd12;
    divisor  = 4'd5;
    tick();
    start    = 1'b0;
    tick();
    start    = 1'b1;
    dividend = 4'd1;
    divisor  = 4'd1;
    tick();
    start    = 1'b0;
    tick();
    chk("ign_done3", int'(done), 0);
    tick();
    chk("ign_done4", int'(done), 1);
    chk("ign_quot", int'(quotient), 2);
    chk("ign_rem", int'(remainder), 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done5", int'(done), 0);
    chk("ign_busy5", int'(busy), 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("ign_nodone", int'(done), 0);
    end
    chk("ign_quot2", int'(quotient), 2);
    chk("ign_rem2", int'(remainder), 2);

    // reset in the middle of a division
    start    = 1'b1;
    dividend = 4'd14;
    divisor  = 4'd3;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("ar_busy", int'(busy), 0);
    chk("ar_done", int'(done), 0);
    chk("ar_quot", int'(quotient), 0);
    chk("ar_rem", int'(remainder), 0);
    chk("ar_dbz", int'(div_by_zero), 0);
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("ar_nodone", int'(done), 0);
    end
    do_div(14, 3, 4, 2, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) do_div(a, b, 15, a, 1);
        else        do_div(a, b, a / b, a % b, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
